// File: rtl/st_bus_tx_if.sv
// Byte write channel from the STM side into the frame back buffer.
// Latency: n/a (signal bundle only).
// Backpressure: a byte moves only on a cycle where wr_valid and wr_ready are both high.
interface st_bus_tx_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/st_bus_tx.sv
// ST-bus frame transmitter: double-buffered byte frame serialised MSB-first on f0/c4 timing.
// Latency: data_to_dt updates one clk50 cycle after each synchronised c4 rising tick.
// Backpressure: wr_ready drops once the back buffer is full; it returns on the cycle after a swap.
// Optional feature macro ST_BUS_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_cnt output.
module st_bus_tx #(
    parameter int FRAME_BITS = 384
) (
    input  logic        clk50,
    input  logic        reset_out_rg,
    input  logic        f0,
    input  logic        c4,
    st_bus_tx_if.slave  wr_bus,
    output logic        data_to_dt,
    output logic        cpu_int,
    output logic        underrun
`ifdef ST_BUS_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int NBYTES = FRAME_BITS / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(FRAME_BITS + 1);

    logic                  f0_s1, f0_s2;
    logic                  c4_s1, c4_s2, c4_s3;
    logic                  c4_tick, frame_start;

    logic [7:0]            buf_q [NBYTES];
    logic [IDX_W-1:0]      wr_idx_q;
    logic                  full_q;
    logic                  rdy_q;
    logic                  wr_accept, last_wr, full_now, swap;

    logic [FRAME_BITS-1:0] load_vec;
    logic [FRAME_BITS-1:0] sh_q;
    logic [CNT_W-1:0]      bit_cnt_q;

    assign c4_tick     = c4_s2 & ~c4_s3;
    assign frame_start = c4_tick & ~f0_s2;

    // A write landing in the frame-start cycle counts toward fullness, so it is folded in here.
    assign wr_accept = wr_bus.wr_valid & rdy_q;
    assign last_wr   = wr_accept && (wr_idx_q == IDX_W'(NBYTES - 1));
    assign full_now  = full_q | last_wr;
    assign swap      = frame_start & full_now;

    assign wr_bus.wr_ready = rdy_q;

    // Two-flop synchronisers for the asynchronous frame pulse and bit clock, plus c4 edge history.
    always_ff @(posedge clk50) begin
        if (reset_out_rg) begin
            f0_s1 <= 1'b1;
            f0_s2 <= 1'b1;
            c4_s1 <= 1'b0;
            c4_s2 <= 1'b0;
            c4_s3 <= 1'b0;
        end else begin
            f0_s1 <= f0;
            f0_s2 <= f0_s1;
            c4_s1 <= c4;
            c4_s2 <= c4_s1;
            c4_s3 <= c4_s2;
        end
    end

    // Back buffer storage; contents are meaningless until full_q/wr_idx_q say otherwise.
    always_ff @(posedge clk50) begin
        if (wr_accept) begin
            buf_q[wr_idx_q] <= wr_bus.wr_data;
        end
    end

    // Write index, full flag and ready; a swap frees the buffer and reopens ready next cycle.
    always_ff @(posedge clk50) begin
        if (reset_out_rg) begin
            wr_idx_q <= '0;
            full_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (swap) begin
            wr_idx_q <= '0;
            full_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else if (last_wr) begin
            wr_idx_q <= '0;
            full_q   <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
            rdy_q <= ~full_q;
        end
    end

    // Frame image for the shift register: buffered bytes (byte 0 at the top) or all-ones on underrun.
    always_comb begin
        load_vec = '1;
        if (swap) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (last_wr && (k == NBYTES - 1)) begin
                    load_vec[FRAME_BITS-1-8*k -: 8] = wr_bus.wr_data;
                end else begin
                    load_vec[FRAME_BITS-1-8*k -: 8] = buf_q[k];
                end
            end
        end
    end

    // Serialiser: frame start presents bit 0 and restarts the count; later ticks shift until saturated.
    always_ff @(posedge clk50) begin
        if (reset_out_rg) begin
            sh_q       <= '1;
            bit_cnt_q  <= CNT_W'(FRAME_BITS);
            data_to_dt <= 1'b1;
            cpu_int    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            cpu_int  <= swap;
            underrun <= frame_start & ~full_now;
            if (frame_start) begin
                data_to_dt <= load_vec[FRAME_BITS-1];
                sh_q       <= {load_vec[FRAME_BITS-2:0], 1'b1};
                bit_cnt_q  <= CNT_W'(1);
            end else if (c4_tick) begin
                if (bit_cnt_q != CNT_W'(FRAME_BITS)) begin
                    data_to_dt <= sh_q[FRAME_BITS-1];
                    sh_q       <= {sh_q[FRAME_BITS-2:0], 1'b1};
                    bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                end else begin
                    data_to_dt <= 1'b1;
                end
            end
        end
    end

`ifdef ST_BUS_TX_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses since reset.
    always_ff @(posedge clk50) begin
        if (reset_out_rg) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/st_bus_tx.md
ST_BUS_TX -- requirements
Module: st_bus_tx

Interface
REQ-001 Parameter FRAME_BITS, default 384, bits per transmitted frame; SHALL be a multiple of 8, range 8..1024.
REQ-002 Port clk50  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset_out_rg  input  1  reset, synchronous, active-high.
REQ-004 Port f0  input  1  asynchronous frame pulse, active-low.
REQ-005 Port c4  input  1  asynchronous bit clock; one bit per c4 rising edge.
REQ-006 Port wr_data  input  8  frame byte from STM side.
REQ-007 Port wr_valid  input  1  wr_data valid.
REQ-008 Port wr_ready  output  1  back buffer can accept a byte.
REQ-009 Port data_to_dt  output  1  serial data to DT line.
REQ-010 Port cpu_int  output  1  one-cycle pulse: back buffer consumed, refill requested.
REQ-011 Port underrun  output  1  one-cycle pulse: frame started with back buffer not full.

Function
REQ-012 f0 and c4 SHALL each pass a 2-flop synchronizer; c4 tick = synchronized c4 0->1, asserted for one clk50 cycle.
REQ-013 Frame start = c4 tick while synchronized f0 is 0.
REQ-014 Buffering: one back buffer (FRAME_BITS/8 bytes, write side) and one shift register (transmit side).
REQ-015 Byte accepted on cycle with wr_valid=1 and wr_ready=1; byte k stored at index k, k = 0..FRAME_BITS/8-1.
REQ-016 After byte FRAME_BITS/8-1 accepted, back buffer full; wr_ready SHALL be 0 from next cycle until swap.
REQ-017 At frame start with back buffer full: copy back buffer to shift register, clear full and write index, pulse cpu_int on the following cycle; wr_ready returns to 1 on that same following cycle.
REQ-018 At frame start with back buffer not full: shift register loaded with all ones, underrun pulsed on the following cycle, partial write index retained.
REQ-019 Transmit order: byte 0 first, MSB first within each byte.
REQ-020 data_to_dt SHALL change exactly one clk50 cycle after the c4 tick that selects the bit; frame-start tick presents bit 0, each further tick presents the next bit.
REQ-021 After bit FRAME_BITS-1, data_to_dt SHALL hold 1 (idle) on further ticks until next frame start.
REQ-022 Frame start arriving before bit FRAME_BITS-1 SHALL abort current frame and begin a new one per REQ-017/018 (resync); remaining bits are discarded.
REQ-023 Frame start coinciding with a byte write: if wr_ready=1 the write is accepted first and counts toward fullness for this swap decision.
REQ-024 Bit counter SHALL saturate at FRAME_BITS; it SHALL NOT wrap without a frame start.

Reset
REQ-025 While reset_out_rg=1: data_to_dt=1, cpu_int=0, underrun=0, wr_ready=0, write index 0, back buffer not full, transmitter idle, synchronizers cleared to f0=1, c4=0.
REQ-026 wr_ready SHALL rise the first cycle after reset_out_rg deasserts.
REQ-027 Reset mid-frame or mid-fill SHALL discard all buffered data; first frame after reset is per REQ-018 unless buffer was refilled.

Configuration
REQ-028 Macro ST_BUS_TX_UNDERRUN_CNT_EN defined: output port underrun_cnt, 16 bits, counts underrun pulses, saturates at 0xFFFF, cleared by reset.
REQ-029 Macro undefined: no underrun_cnt port or counter logic; all other behaviour identical.

Verification
REQ-030 Fill 48 bytes 0x00..0x2F, f0 low at c4 tick -> data_to_dt serializes 0x00,0x01,...,0x2F MSB first over 384 ticks; cpu_int one pulse; then idle 1.
REQ-031 Write only 10 bytes, frame start -> 384 bits of 1, underrun pulse, wr_ready stays 1; write 38 more, next frame transmits all 48 bytes.
REQ-032 Full buffer, wr_valid held 1 -> wr_ready 0, no extra byte stored; after swap cycle wr_ready 1.
REQ-033 Second f0 after 100 bits -> bit 101 not sent, new frame bit 0 appears one cycle after that tick.
REQ-034 reset_out_rg pulsed at bit 200 -> data_to_dt 1 next cycle, wr_ready 0 during reset, 1 one cycle after release.
REQ-035 With ST_BUS_TX_UNDERRUN_CNT_EN, three empty frames -> underrun_cnt = 3.
